// File: rtl/instruction_fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory, branch/hazard logic and the IF/ID stage.
// The fetch unit takes the master side; memory and the surrounding pipeline take the slave side.
interface instruction_fetch_unit_if;
    logic [31:0] Branch_target;
    logic        Branch_taken;
    logic        Stall;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ready;
    logic [31:0] Imem_rdata;
    logic [31:0] IFID_pc;
    logic [31:0] IFID_instr;
    logic        IFID_valid;

    modport master (
        input  Branch_target,
        input  Branch_taken,
        input  Stall,
        input  Imem_ready,
        input  Imem_rdata,
        output Imem_req,
        output Imem_addr,
        output IFID_pc,
        output IFID_instr,
        output IFID_valid
    );

    modport slave (
        output Branch_target,
        output Branch_taken,
        output Stall,
        output Imem_ready,
        output Imem_rdata,
        input  Imem_req,
        input  Imem_addr,
        input  IFID_pc,
        input  IFID_instr,
        input  IFID_valid
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: issues word fetches, absorbs decode stalls in a one-entry hold
// buffer and drops words belonging to a path that a taken branch has redirected away from.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic                            CLK,
    input  logic                            RESET,
    instruction_fetch_unit_if.master        bus_io
);
    localparam logic [1:0] StFetch   = 2'd0;
    localparam logic [1:0] StHold    = 2'd1;
    localparam logic [1:0] StDiscard = 2'd2;

    localparam logic [31:0] NopInstr = 32'h00000013;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target   = {bus_io.Branch_target[31:2], 2'b00};
    assign pc_plus4 = fetch_pc_q + 32'd4;

    assign bus_io.Imem_req   = RESET && (state_q != StHold);
    assign bus_io.Imem_addr  = {fetch_pc_q[31:2], 2'b00};
    assign bus_io.IFID_pc    = ifid_pc_q;
    assign bus_io.IFID_instr = ifid_instr_q;
    assign bus_io.IFID_valid = ifid_valid_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;

        unique case (state_q)
            StHold: begin
                if (bus_io.Branch_taken) begin
                    fetch_pc_d   = target;
                    ifid_valid_d = 1'b0;
                    state_d      = StFetch;
                end else if (!bus_io.Stall) begin
                    ifid_pc_d    = hold_pc_q;
                    ifid_instr_d = hold_instr_q;
                    ifid_valid_d = 1'b1;
                    state_d      = StFetch;
                end
            end
            StDiscard: begin
                ifid_valid_d = 1'b0;
                // A branch arriving in the same cycle as the stale word still wins.
                if (bus_io.Branch_taken) begin
                    redirect_pc_d = target;
                end
                if (bus_io.Imem_ready) begin
                    fetch_pc_d = bus_io.Branch_taken ? target : redirect_pc_q;
                    state_d    = StFetch;
                end
            end
            default: begin
                if (bus_io.Branch_taken) begin
                    ifid_valid_d = 1'b0;
                    if (bus_io.Imem_ready) begin
                        fetch_pc_d = target;
                    end else begin
                        redirect_pc_d = target;
                        state_d       = StDiscard;
                    end
                end else if (bus_io.Imem_ready) begin
                    fetch_pc_d = pc_plus4;
                    if (bus_io.Stall) begin
                        hold_pc_d    = fetch_pc_q;
                        hold_instr_d = bus_io.Imem_rdata;
                        state_d      = StHold;
                    end else begin
                        ifid_pc_d    = fetch_pc_q;
                        ifid_instr_d = bus_io.Imem_rdata;
                        ifid_valid_d = 1'b1;
                    end
                end else if (!bus_io.Stall) begin
                    ifid_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q       <= StFetch;
            fetch_pc_q    <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            hold_pc_q     <= 32'd0;
            hold_instr_q  <= 32'd0;
            ifid_pc_q     <= 32'd0;
            ifid_instr_q  <= NopInstr;
            ifid_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a transaction-level model checked every cycle
// plus hand-computed expectations for the stream, stall, redirect, wrap and reset scenarios.
module tb_instruction_fetch_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic CLK = 1'b0;
    logic RESET;
    int   ntests = 0;
    int   nfail  = 0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC(32'h00000000)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus_io(bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return {addr[29:0], 2'b11} ^ 32'h5A000000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Model: the next address to fetch, an optional parked word, and an optional pending redirect
    // whose stale word is still owed by memory.
    logic [31:0] m_pc;
    logic [31:0] m_target;
    bit          m_discard;
    entry_t      m_held[$];
    entry_t      m_ifid;
    bit          m_valid;
    bit          chk_en = 0;

    initial begin
        forever begin
            @(posedge CLK);
            if (!RESET) begin
                m_pc      = 32'h0;
                m_target  = 32'h0;
                m_discard = 0;
                m_held.delete();
                m_ifid    = '{pc: 32'h0, instr: 32'h00000013};
                m_valid   = 0;
                chk_en    = 1;
            end else if (m_held.size() != 0) begin
                if (bus.Branch_taken) begin
                    m_held.delete();
                    m_pc    = bus.Branch_target & ~32'h3;
                    m_valid = 0;
                end else if (!bus.Stall) begin
                    m_ifid  = m_held.pop_front();
                    m_valid = 1;
                end
            end else if (m_discard) begin
                m_valid = 0;
                if (bus.Branch_taken) m_target = bus.Branch_target & ~32'h3;
                if (bus.Imem_ready) begin
                    m_pc      = m_target;
                    m_discard = 0;
                end
            end else if (bus.Branch_taken) begin
                m_valid = 0;
                if (bus.Imem_ready) begin
                    m_pc = bus.Branch_target & ~32'h3;
                end else begin
                    m_target  = bus.Branch_target & ~32'h3;
                    m_discard = 1;
                end
            end else if (bus.Imem_ready) begin
                if (bus.Stall) begin
                    m_held.push_back('{pc: m_pc, instr: bus.Imem_rdata});
                end else begin
                    m_ifid  = '{pc: m_pc, instr: bus.Imem_rdata};
                    m_valid = 1;
                end
                m_pc = m_pc + 32'd4;
            end else if (!bus.Stall) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            logic exp_req;
            exp_req = RESET && (m_held.size() == 0);
            chk("cyc_req", {31'd0, bus.Imem_req}, {31'd0, exp_req});
            if (exp_req) chk("cyc_addr", bus.Imem_addr, m_pc);
            chk("cyc_valid", {31'd0, bus.IFID_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("cyc_pc", bus.IFID_pc, m_ifid.pc);
                chk("cyc_instr", bus.IFID_instr, m_ifid.instr);
            end
        end
    end

    logic [31:0] vlog[$];

    task automatic cyc(input logic rdy, input logic stl, input logic tkn, input logic [31:0] tgt);
        bus.Imem_ready    = rdy;
        bus.Stall         = stl;
        bus.Branch_taken  = tkn;
        bus.Branch_target = tgt;
        bus.Imem_rdata    = instr_of(bus.Imem_addr);
        @(posedge CLK);
        #1;
        if (bus.IFID_valid) vlog.push_back(bus.IFID_pc);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        RESET = 1'b1;
        #1;
    endtask

    // {ready, stall, taken, target} mixes of bubbles, stalls and redirects.
    logic [34:0] vec[12] = '{
        {3'b000, 32'h0}, {3'b010, 32'h0}, {3'b100, 32'h0}, {3'b110, 32'h0},
        {3'b010, 32'h0}, {3'b000, 32'h0}, {3'b011, 32'h804}, {3'b000, 32'h0},
        {3'b111, 32'h900}, {3'b100, 32'h0}, {3'b101, 32'hA00}, {3'b100, 32'h0}
    };

    initial begin
        RESET             = 1'b0;
        bus.Imem_ready    = 1'b0;
        bus.Stall         = 1'b0;
        bus.Branch_taken  = 1'b0;
        bus.Branch_target = 32'h0;
        bus.Imem_rdata    = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc", bus.IFID_pc, 32'h0);
        chk("rst_instr", bus.IFID_instr, 32'h00000013);
        chk("rst_valid", {31'd0, bus.IFID_valid}, 32'd0);
        chk("rst_req", {31'd0, bus.Imem_req}, 32'd0);
        RESET = 1'b1;
        #1;
        chk("first_req", {31'd0, bus.Imem_req}, 32'd1);
        chk("first_addr", bus.Imem_addr, 32'h0);

        // Zero-wait stream
        vlog.delete();
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("stream_len", vlog.size(), 32'd4);
        for (int i = 0; i < 4 && i < vlog.size(); i++) chk("stream_pc", vlog[i], 32'(i * 4));

        // Stall during return of the word at 0x8
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("hold_pc", bus.IFID_pc, 32'h4);
        chk("hold_req", {31'd0, bus.Imem_req}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("hold_pc2", bus.IFID_pc, 32'h4);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("release_pc", bus.IFID_pc, 32'h8);
        chk("release_instr", bus.IFID_instr, instr_of(32'h8));
        chk("release_valid", {31'd0, bus.IFID_valid}, 32'd1);
        chk("release_addr", bus.Imem_addr, 32'hC);

        // Redirect with wait states while 0x10 is pending
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        vlog.delete();
        cyc(1'b0, 1'b0, 1'b1, 32'h100);
        chk("disc_addr", bus.Imem_addr, 32'h10);
        chk("disc_valid", {31'd0, bus.IFID_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("disc_addr2", bus.Imem_addr, 32'h10);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir_addr", bus.Imem_addr, 32'h100);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir_pc", bus.IFID_pc, 32'h100);
        foreach (vlog[i]) chk("no_stale", {31'd0, vlog[i] == 32'h10}, 32'd0);

        // Double redirect in DISCARD
        cyc(1'b0, 1'b0, 1'b1, 32'h100);
        cyc(1'b0, 1'b0, 1'b1, 32'h200);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("double_redir", bus.Imem_addr, 32'h200);

        // Stall and branch together in HOLD
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("hold2_req", {31'd0, bus.Imem_req}, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 32'h400);
        chk("flush_valid", {31'd0, bus.IFID_valid}, 32'd0);
        chk("flush_addr", bus.Imem_addr, 32'h400);

        // Unaligned target, then wrap past the top of memory
        cyc(1'b1, 1'b0, 1'b1, 32'h503);
        chk("align_addr", bus.Imem_addr, 32'h500);
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc", bus.IFID_pc, 32'hFFFFFFFC);
        chk("wrap_addr", bus.Imem_addr, 32'h0);

        // Reset in the middle of DISCARD with a late ready
        cyc(1'b0, 1'b0, 1'b1, 32'h40);
        RESET = 1'b0;
        #1;
        chk("rstmid_req", {31'd0, bus.Imem_req}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        RESET = 1'b1;
        #1;
        chk("rstmid_addr", bus.Imem_addr, 32'h0);
        chk("rstmid_valid", {31'd0, bus.IFID_valid}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rstmid_pc", bus.IFID_pc, 32'h0);
        chk("rstmid_ivalid", {31'd0, bus.IFID_valid}, 32'd1);

        foreach (vec[i]) cyc(vec[i][34], vec[i][33], vec[i][32], vec[i][31:0]);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
